spi_tx_sched: RTL and testbench
===============================

// Module: spi_tx_sched
// PURPOSE
// Round-robin scheduler that shares one SPI TX chip-select sequencer between NREQ requesters.
// Arbitrates req, loads the winner's CS-high delay onto del_csh and pulses tx_valid.
// Tracks the transaction through the sequencer's tx_idle, then returns done to the winner.
// Sits between the per-channel command logic and the single CS sequencer / shift engine.
// PARAMETERS
// NREQ   4   number of requesters, 2..8
// SPI0_2 32  width of CS-high delay field, matching the sequencer del_csh port
// TMO_W  16  watchdog counter width; TMO_MAX = 2**TMO_W-1 cycles in S_RUN
// PORTS
// clk       in   1            system clock, all logic on posedge
// rst_n     in   1            asynchronous active-low reset
// req       in   NREQ         level request per requester
// req_csh   in   NREQ*SPI0_2  per-requester CS-high delay; slice i = [i*SPI0_2 +: SPI0_2]
// gnt       out  NREQ         one-hot grant, held for the whole transaction
// done      out  NREQ         1-cycle completion pulse to the granted requester
// err       out  1            1-cycle watchdog timeout pulse
// busy      out  1            high whenever state != S_ARB
// del_csh   out  SPI0_2       CS-high delay to the sequencer, stable while gnt != 0
// tx_valid  out  1            start strobe to the sequencer
// tx_idle   in   1            sequencer idle flag
// BEHAVIOUR
// - Reset values: gnt=0, done=0, err=0, busy=1, del_csh=0, tx_valid=0, rr_ptr=0, state=S_WAIT.
//   All outputs are registered.
// - S_WAIT: wait for tx_idle=1 (the sequencer exits reset via its completion state), then go to S_ARB.
// - S_ARB: if tx_idle=1 and req!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   Next cycle: gnt[w]=1, del_csh=req_csh slice w, tx_valid=1, state=S_START.
//   Latency is 1 cycle from req sampled to gnt/tx_valid.
// - S_START: hold tx_valid=1 until tx_idle samples 0.
//   Then tx_valid=0, clear watchdog, state=S_RUN.
//   A single transaction is guaranteed: the sequencer ignores tx_valid outside its idle state.
// - S_RUN: watchdog increments each cycle. When tx_idle samples 1, go to S_DONE.
//   If the watchdog reaches TMO_MAX first: err=1 for 1 cycle, done=0, gnt=0, go to S_WAIT.
// - S_DONE: done[w]=1 for exactly one cycle. Next cycle: gnt=0, rr_ptr=(w+1) mod NREQ, state=S_ARB.
// - The watchdog also runs in S_START with the same timeout action.
// - del_csh and gnt change only on the S_ARB->S_START edge and on exit to S_ARB/S_WAIT.
//   req_csh changes mid-transaction are ignored.
// - If a requester drops req after grant, the transaction still completes and done still pulses.
// - A req still high in the cycle after done is a new request at the lowest priority.
// - Simultaneous requests: resolved purely by rr_ptr, so no requester waits more than NREQ-1 grants.
// - tx_idle=0 in S_ARB blocks arbitration; requests stay pending and no gnt is issued.
// - rst_n low mid-transaction: everything returns to reset values immediately; no done, no err.
// - Minimum turnaround done -> next tx_valid is 2 cycles (S_DONE, S_ARB).
// TESTING
// - Reset then release with tx_idle=1: S_WAIT->S_ARB in 1 cycle, busy=0, all outputs 0.
// - req=4'b0100, req_csh[2]=10, sequencer model 20 cycles:
//   gnt=0100 and del_csh=10 next cycle, tx_valid high exactly 2 cycles, done[2] 1 cycle after tx_idle=1.
// - req=4'b1111 held, rr_ptr=0: grant order 0,1,2,3,0 with one done per grant, no gaps beyond 2 cycles.
// - Model never returns tx_idle=1, TMO_W=4: err pulses 15 cycles into the wait, gnt clears, done stays 0.
// - req_csh[1] changed mid-transaction: del_csh keeps the value latched at grant until done.
// - rst_n asserted low during S_RUN: gnt/tx_valid drop asynchronously, rr_ptr=0, restart in S_WAIT.

Source files
------------

// File: rtl/spi_tx_sched_if.sv
// Request/grant and sequencer handshake bundle for spi_tx_sched.
// master = the scheduler, slave = requesters plus the CS sequencer.
interface spi_tx_sched_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SPI0_2 = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ*SPI0_2-1:0] req_csh;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic                   busy;
  logic [SPI0_2-1:0]      del_csh;
  logic                   tx_valid;
  logic                   tx_idle;

  modport master (
    input  req, req_csh, tx_idle,
    output gnt, done, err, busy, del_csh, tx_valid
  );

  modport slave (
    output req, req_csh, tx_idle,
    input  gnt, done, err, busy, del_csh, tx_valid
  );
endinterface

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one SPI TX CS sequencer between NREQ requesters,
// with a watchdog on the start/run phases. All outputs are registered.
module spi_tx_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SPI0_2 = 32,
  parameter int unsigned TMO_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_tx_sched_if.master bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_WAIT, S_ARB, S_START, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic              err_q, err_d, busy_q, busy_d, txv_q, txv_d;
  logic [SPI0_2-1:0] del_q, del_d;
  logic [PW-1:0]     rr_q, rr_d, win_q, win_d;
  logic [TMO_W-1:0]  wd_q, wd_d, wd_inc;
  logic [PW-1:0]     pick, cand;
  logic              pick_vld;
  int unsigned       idx;

  // Scan rr_q, rr_q+1, ... mod NREQ; first pending request wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx  = (32'(rr_q) + i) % NREQ;
      cand = PW'(idx);
      if (!pick_vld && bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    txv_d   = txv_q;
    del_d   = del_q;
    rr_d    = rr_q;
    win_d   = win_q;
    wd_d    = wd_q;
    wd_inc  = wd_q + 1'b1;

    case (state_q)
      S_WAIT: begin
        if (bus.tx_idle) state_d = S_ARB;
      end
      S_ARB: begin
        if (bus.tx_idle && pick_vld) begin
          state_d     = S_START;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          del_d       = bus.req_csh[32'(pick)*SPI0_2 +: SPI0_2];
          txv_d       = 1'b1;
          win_d       = pick;
          wd_d        = '0;
        end
      end
      S_START, S_RUN: begin
        // Sequencer handshake takes priority over a coincident watchdog expiry.
        wd_d = wd_inc;
        if (state_q == S_START && !bus.tx_idle) begin
          state_d = S_RUN;
          txv_d   = 1'b0;
          wd_d    = '0;
        end else if (state_q == S_RUN && bus.tx_idle) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else if (wd_inc == '1) begin
          state_d = S_WAIT;
          err_d   = 1'b1;
          gnt_d   = '0;
          del_d   = '0;
          txv_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_ARB;
        gnt_d   = '0;
        del_d   = '0;
        rr_d    = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_WAIT;
    endcase

    busy_d = (state_d != S_ARB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      txv_q   <= 1'b0;
      del_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      txv_q   <= txv_d;
      del_q   <= del_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.del_csh  = del_q;
  assign bus.tx_valid = txv_q;
endmodule

// File: tb/tb_spi_tx_sched.sv
// Directed bench for spi_tx_sched: a main instance driven by a CS sequencer model
// and a short-watchdog instance whose tx_idle is driven by hand.
module tb_spi_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_tx_sched_if #(.NREQ(4), .SPI0_2(32)) b ();
  spi_tx_sched_if #(.NREQ(4), .SPI0_2(32)) b2 ();

  spi_tx_sched #(.NREQ(4), .SPI0_2(32), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  spi_tx_sched #(.NREQ(4), .SPI0_2(32), .TMO_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  // Sequencer model: accepts tx_valid only while idle, then stays busy seq_len cycles.
  logic seq_idle;
  int   seq_cnt;
  int   seq_len = 20;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_idle <= 1'b1;
      seq_cnt  <= 0;
    end else if (seq_idle) begin
      if (b.tx_valid) begin
        seq_idle <= 1'b0;
        seq_cnt  <= seq_len - 1;
      end
    end else if (seq_cnt == 0) begin
      seq_idle <= 1'b1;
    end else begin
      seq_cnt <= seq_cnt - 1;
    end
  end
  assign b.tx_idle = seq_idle;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int bad;
    int early;
    int cyc;
    logic [3:0] w1h;

    b.req      = '0;
    b.req_csh  = '0;
    b2.req     = '0;
    b2.req_csh = '0;
    b2.tx_idle = 1'b1;

    // Reset values
    tick(); tick();
    chk("rst_gnt", 64'(b.gnt), 64'h0);
    chk("rst_done", 64'(b.done), 64'h0);
    chk("rst_err", 64'(b.err), 64'h0);
    chk("rst_busy", 64'(b.busy), 64'h1);
    chk("rst_del", 64'(b.del_csh), 64'h0);
    chk("rst_txv", 64'(b.tx_valid), 64'h0);

    // Release: one cycle in S_WAIT with tx_idle=1 gives S_ARB
    rst_n = 1'b1;
    tick();
    chk("arb_busy", 64'(b.busy), 64'h0);
    chk("arb_gnt", 64'(b.gnt), 64'h0);
    chk("arb_txv", 64'(b.tx_valid), 64'h0);

    // Single request 2, 20-cycle transaction, req dropped after grant
    b.req_csh[2*32 +: 32] = 32'd10;
    b.req = 4'b0100;
    tick();
    chk("t1_gnt", 64'(b.gnt), 64'h4);
    chk("t1_del", 64'(b.del_csh), 64'd10);
    chk("t1_txv0", 64'(b.tx_valid), 64'h1);
    chk("t1_busy", 64'(b.busy), 64'h1);
    b.req = '0;
    tick();
    chk("t1_txv1", 64'(b.tx_valid), 64'h1);
    tick();
    chk("t1_txv2", 64'(b.tx_valid), 64'h0);
    early = 0;
    bad = 0;
    for (int i = 3; i <= 21; i++) begin
      tick();
      if (b.done != 4'b0000) early++;
      if (b.gnt != 4'b0100) bad++;
    end
    chk("t1_seq_idle_back", 64'(seq_idle), 64'h1);
    chk("t1_no_early_done", 64'(early), 64'd0);
    chk("t1_gnt_held", 64'(bad), 64'd0);
    tick();
    chk("t1_done", 64'(b.done), 64'h4);
    tick();
    chk("t1_done_1cyc", 64'(b.done), 64'h0);
    chk("t1_gnt_clr", 64'(b.gnt), 64'h0);
    chk("t1_del_clr", 64'(b.del_csh), 64'h0);
    chk("t1_busy_clr", 64'(b.busy), 64'h0);

    // rr_ptr now 3: requester 1 wins; req_csh change mid-transaction ignored
    seq_len = 6;
    b.req_csh[1*32 +: 32] = 32'h55;
    b.req = 4'b0010;
    tick();
    chk("t3_gnt", 64'(b.gnt), 64'h2);
    chk("t3_del", 64'(b.del_csh), 64'h55);
    b.req = '0;
    b.req_csh[1*32 +: 32] = 32'hAA;
    bad = 0;
    cyc = 0;
    while (b.done == 4'b0000 && cyc < 60) begin
      tick();
      cyc++;
      if (b.del_csh != 32'h55) bad++;
    end
    chk("t3_del_stable", 64'(bad), 64'd0);
    chk("t3_done", 64'(b.done), 64'h2);

    // rr_ptr now 2: requester 0 wins, then reset in S_RUN
    tick();
    b.req = 4'b0001;
    tick();
    chk("t4_gnt", 64'(b.gnt), 64'h1);
    b.req = '0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_gnt", 64'(b.gnt), 64'h0);
    chk("t4_rst_txv", 64'(b.tx_valid), 64'h0);
    chk("t4_rst_busy", 64'(b.busy), 64'h1);
    chk("t4_rst_done", 64'(b.done), 64'h0);
    tick();
    b.req = 4'b1111;
    seq_len = 3;
    rst_n = 1'b1;
    tick();
    chk("t4_arb_busy", 64'(b.busy), 64'h0);

    // All four requesting from rr_ptr=0: order 0,1,2,3,0, 2-cycle turnaround
    for (int k = 0; k < 5; k++) begin
      w1h = 4'b0001 << (k % 4);
      tick();
      chk("rr_gnt", 64'(b.gnt), 64'(w1h));
      chk("rr_txv", 64'(b.tx_valid), 64'h1);
      cyc = 0;
      while (b.done == 4'b0000 && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("rr_done", 64'(b.done), 64'(w1h));
      if (k == 4) b.req = '0;
      tick();
      chk("rr_gap_gnt", 64'(b.gnt), 64'h0);
      chk("rr_gap_txv", 64'(b.tx_valid), 64'h0);
    end

    // Watchdog on the TMO_W=4 instance: tx_idle never returns
    b2.req_csh[0 +: 32] = 32'd7;
    b2.req = 4'b0001;
    tick();
    chk("wd_gnt", 64'(b2.gnt), 64'h1);
    chk("wd_del", 64'(b2.del_csh), 64'd7);
    b2.req = '0;
    b2.tx_idle = 1'b0;
    tick();
    chk("wd_txv_off", 64'(b2.tx_valid), 64'h0);
    early = 0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (b2.err || b2.done != 4'b0000) early++;
      if (b2.gnt != 4'b0001) bad++;
    end
    chk("wd_no_early", 64'(early), 64'd0);
    chk("wd_gnt_held", 64'(bad), 64'd0);
    tick();
    chk("wd_err", 64'(b2.err), 64'h1);
    chk("wd_gnt_clr", 64'(b2.gnt), 64'h0);
    chk("wd_done0", 64'(b2.done), 64'h0);
    chk("wd_busy", 64'(b2.busy), 64'h1);
    tick();
    chk("wd_err_1cyc", 64'(b2.err), 64'h0);
    chk("wd_wait_busy", 64'(b2.busy), 64'h1);
    b2.tx_idle = 1'b1;
    tick();
    chk("wd_back_arb", 64'(b2.busy), 64'h0);

    // tx_idle=0 in S_ARB blocks arbitration; request stays pending
    b2.tx_idle = 1'b0;
    b2.req = 4'b0010;
    tick(); tick(); tick();
    chk("blk_gnt", 64'(b2.gnt), 64'h0);
    chk("blk_txv", 64'(b2.tx_valid), 64'h0);
    b2.tx_idle = 1'b1;
    tick();
    chk("blk_release_gnt", 64'(b2.gnt), 64'h2);
    chk("blk_release_txv", 64'(b2.tx_valid), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
